// File: rtl/vram_pkg.sv
// Shared definitions for the video RAM arbiter: bus widths, FSM states and
// access-owner encoding.
package vram_pkg;

   localparam int AW = 14;
   localparam int DW = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2
   } state_t;

   typedef enum logic {
      OWN_VID = 1'b0,
      OWN_CPU = 1'b1
   } owner_t;

endpackage

// File: rtl/vram_arbiter.sv
// Arbitrates the single-port video RAM between the hard real-time video fetch
// (absolute priority) and the Z80 bus (req/ack with derived wait state).
module vram_arbiter #(
   parameter int AW = vram_pkg::AW,
   parameter int DW = vram_pkg::DW
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic [DW-1:0] vid_data,
   output logic          vid_valid,
   output logic          vid_overrun,
   input  logic          ovr_clr,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_wait,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);
   import vram_pkg::*;

   state_t          state;
   state_t          state_nxt;
   owner_t          owner;
   logic            acc_we;
   logic            vid_pend;
   logic [AW-1:0]   vid_pa;
   logic            grant_vid_pend;
   logic            grant_vid_new;
   logic            grant_cpu;
   logic            ack_raise;
   logic            vid_done;

   assign cpu_wait = cpu_req & ~cpu_ack;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // A fresh video request with nothing pending is granted on the same edge,
   // which is what gives the two-cycle video latency from idle.
   always_comb begin
      state_nxt      = state;
      grant_vid_pend = 1'b0;
      grant_vid_new  = 1'b0;
      grant_cpu      = 1'b0;
      ack_raise      = (state == ST_CAPTURE) && (owner == OWN_CPU);
      vid_done       = (state == ST_CAPTURE) && (owner == OWN_VID);
      case (state)
         ST_IDLE, ST_CAPTURE: begin
            if (vid_pend)                   grant_vid_pend = 1'b1;
            else if (vid_req)               grant_vid_new  = 1'b1;
            else if (cpu_req && !ack_raise) grant_cpu      = 1'b1;
            if (grant_vid_pend || grant_vid_new || grant_cpu) state_nxt = ST_ISSUE;
            else                                              state_nxt = ST_IDLE;
         end
         ST_ISSUE: state_nxt = ST_CAPTURE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         owner       <= OWN_VID;
         acc_we      <= 1'b0;
         vid_pend    <= 1'b0;
         vid_pa      <= '0;
         vid_data    <= '0;
         vid_valid   <= 1'b0;
         vid_overrun <= 1'b0;
         cpu_ack     <= 1'b0;
         cpu_rdata   <= '0;
         mem_addr    <= '0;
         mem_we      <= 1'b0;
         mem_wdata   <= '0;
      end else begin
         vid_valid <= vid_done;
         cpu_ack   <= ack_raise;
         mem_we    <= 1'b0;

         if (vid_done)               vid_data  <= mem_rdata;
         if (ack_raise && !acc_we)   cpu_rdata <= mem_rdata;

         if (grant_vid_pend) begin
            owner    <= OWN_VID;
            mem_addr <= vid_pa;
         end else if (grant_vid_new) begin
            owner    <= OWN_VID;
            mem_addr <= vid_addr;
         end else if (grant_cpu) begin
            owner     <= OWN_CPU;
            acc_we    <= cpu_we;
            mem_addr  <= cpu_addr;
            mem_we    <= cpu_we;
            mem_wdata <= cpu_wdata;
         end

         // Latest request wins the pending slot; the older address is dropped.
         if (vid_req && !grant_vid_new) begin
            vid_pend <= 1'b1;
            vid_pa   <= vid_addr;
         end else if (grant_vid_pend) begin
            vid_pend <= 1'b0;
         end

         if (vid_req && vid_pend && !grant_vid_pend) vid_overrun <= 1'b1;
         else if (ovr_clr)                           vid_overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: synchronous RAM model, directed cases and
// a mixed video/CPU traffic run checked against a reference memory image.
module tb_vram_arbiter;

   logic        clock;
   logic        reset_n;
   logic        vid_req;
   logic [13:0] vid_addr;
   logic [7:0]  vid_data;
   logic        vid_valid;
   logic        vid_overrun;
   logic        ovr_clr;
   logic        cpu_req;
   logic        cpu_we;
   logic [13:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic        cpu_wait;
   logic [13:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   vram_arbiter dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .vid_req     (vid_req),
      .vid_addr    (vid_addr),
      .vid_data    (vid_data),
      .vid_valid   (vid_valid),
      .vid_overrun (vid_overrun),
      .ovr_clr     (ovr_clr),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_ack     (cpu_ack),
      .cpu_rdata   (cpu_rdata),
      .cpu_wait    (cpu_wait),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   typedef struct {
      logic [7:0] data;
      int         t;
      int         lmin;
      int         lmax;
   } vexp_t;

   typedef struct {
      logic       we;
      logic [7:0] data;
      int         t;
      int         lmin;
      int         lmax;
   } cexp_t;

   vexp_t       vid_q[$];
   cexp_t       cpu_q[$];
   logic [7:0]  ram     [0:16383];
   logic [7:0]  ref_ram [0:16383];
   bit          ram_ready;
   logic [7:0]  exp_rdata;
   int          cyc;
   int          n_checks;
   int          n_fail;
   int          we_run;
   int          we_total;
   int          vid_count;
   int          ack_count;
   logic [13:0] last_we_addr;
   vexp_t       mv;
   cexp_t       mc;
   int          mlat;
   bit          stop;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [7:0] init_val(input int a);
      if (a == 'h2000) return 8'h5A;
      return 8'(a) ^ 8'(a >> 6);
   endfunction

   always @(posedge clock) begin
      if (!ram_ready) begin
         for (int a = 0; a < 16384; a++) ram[a] <= init_val(a);
         ram_ready <= 1'b1;
      end else begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         mem_rdata <= ram[mem_addr];
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Output monitor: pops the scoreboards on vid_valid / cpu_ack.
   always @(negedge clock) begin
      if (reset_n) begin
         if (mem_we) we_run++;
         else        we_run = 0;
         if (mem_we) begin
            we_total++;
            last_we_addr = mem_addr;
            check_val("mem_we_run", we_run, 1);
         end
         if (vid_valid) begin
            vid_count++;
            if (vid_q.size() == 0) check_val("vid_spurious", vid_q.size(), 1);
            else begin
               mv   = vid_q.pop_front();
               mlat = cyc - mv.t;
               check_val("vid_data", vid_data, mv.data);
               if (mv.lmin == mv.lmax) check_val("vid_lat", mlat, mv.lmin);
               else check_val("vid_lat_rng", (mlat >= mv.lmin) && (mlat <= mv.lmax), 1);
            end
         end
         if (cpu_ack) begin
            ack_count++;
            if (cpu_q.size() == 0) check_val("cpu_spurious", cpu_q.size(), 1);
            else begin
               mc   = cpu_q.pop_front();
               mlat = cyc - mc.t;
               check_val("cpu_rdata", cpu_rdata, mc.data);
               if (mc.lmin == mc.lmax) check_val("cpu_lat", mlat, mc.lmin);
               else check_val("cpu_lat_rng", (mlat >= mc.lmin) && (mlat <= mc.lmax), 1);
            end
         end
      end
   end

   task automatic vid_set(input logic [13:0] addr, input int lmin, input int lmax);
      vexp_t e;
      vid_req  = 1'b1;
      vid_addr = addr;
      e.data = ref_ram[addr];
      e.t    = cyc + 1;
      e.lmin = lmin;
      e.lmax = lmax;
      vid_q.push_back(e);
   endtask

   task automatic cpu_access(input logic we, input logic [13:0] addr, input logic [7:0] wdata,
                             input int lmin, input int lmax);
      cexp_t e;
      bit    got;
      @(negedge clock);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      if (we) ref_ram[addr] = wdata;
      else    exp_rdata     = ref_ram[addr];
      e.we   = we;
      e.data = exp_rdata;
      e.t    = cyc + 1;
      e.lmin = lmin;
      e.lmax = lmax;
      cpu_q.push_back(e);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clock);
         if (cpu_ack) got = 1'b1;
         else         check_val("cpu_wait", cpu_wait, 1);
      end
      if (!got) check_val("cpu_ack_timeout", cpu_ack, 1);
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
   endtask

   initial begin
      int vc0;
      int wt0;
      int ac0;
      int mism;
      reset_n   = 1'b0;
      vid_req   = 1'b0;
      vid_addr  = '0;
      ovr_clr   = 1'b0;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      exp_rdata = '0;
      stop      = 1'b0;
      for (int a = 0; a < 16384; a++) ref_ram[a] = init_val(a);

      #1;
      check_val("rst_outs_t0", {vid_data, vid_valid, vid_overrun, cpu_ack, cpu_rdata,
                                cpu_wait, mem_addr, mem_we, mem_wdata}, 64'd0);
      repeat (3) @(negedge clock);
      check_val("rst_outs", {vid_data, vid_valid, vid_overrun, cpu_ack, cpu_rdata,
                             cpu_wait, mem_addr, mem_we, mem_wdata}, 64'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // Video read from idle
      vc0 = vid_count;
      vid_set(14'h2000, 2, 2);
      @(negedge clock);
      vid_req = 1'b0;
      repeat (3) begin
         @(negedge clock);
         check_val("vid_idle_wait", cpu_wait, 0);
      end
      check_val("vid_idle_data", vid_data, 8'h5A);
      check_val("vid_idle_cnt", vid_count - vc0, 1);

      // CPU write then read back
      wt0 = we_total;
      cpu_access(1'b1, 14'h03A5, 8'hC3, 2, 2);
      @(negedge clock);
      check_val("wr_we_cycles", we_total - wt0, 1);
      check_val("wr_we_addr", last_we_addr, 14'h03A5);
      cpu_access(1'b0, 14'h03A5, 8'h00, 2, 2);
      check_val("rd_data", cpu_rdata, 8'hC3);
      @(negedge clock);

      // Collision: video first, CPU after four clocks
      fork
         cpu_access(1'b0, 14'h0100, 8'h00, 4, 4);
         begin
            @(negedge clock);
            vid_set(14'h2100, 2, 2);
            @(negedge clock);
            vid_req = 1'b0;
         end
      join
      repeat (2) @(negedge clock);

      // Overrun: the middle request is displaced by the third
      vc0 = vid_count;
      fork
         cpu_access(1'b0, 14'h0200, 8'h00, 2, 2);
         begin
            @(negedge clock);
            @(negedge clock);
            vid_set(14'h2201, 3, 3);
            @(negedge clock);
            vid_req  = 1'b1;
            vid_addr = 14'h2202;
            @(negedge clock);
            vid_set(14'h2203, 3, 3);
            @(negedge clock);
            vid_req = 1'b0;
         end
      join
      repeat (6) @(negedge clock);
      check_val("ovr_set", vid_overrun, 1);
      check_val("ovr_reads", vid_count - vc0, 2);
      check_val("ovr_last_data", vid_data, ref_ram[14'h2203]);
      ovr_clr = 1'b1;
      @(negedge clock);
      ovr_clr = 1'b0;
      check_val("ovr_clr", vid_overrun, 0);

      // Reset during ISSUE of a CPU read
      @(negedge clock);
      cpu_addr = 14'h0050;
      cpu_we   = 1'b0;
      cpu_req  = 1'b1;
      @(negedge clock);
      reset_n = 1'b0;
      cpu_req = 1'b0;
      #1;
      check_val("rst_mid_outs", {vid_data, vid_valid, vid_overrun, cpu_ack, cpu_rdata,
                                 cpu_wait, mem_addr, mem_we, mem_wdata}, 64'd0);
      exp_rdata = '0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      ac0 = ack_count;
      repeat (8) @(negedge clock);
      check_val("rst_no_ack", ack_count, ac0);

      // Stress: periodic video plus continuous CPU traffic
      fork
         begin
            for (int k = 0; k < 312; k++) begin
               @(negedge clock);
               vid_set(14'h2000 + 14'($urandom_range(0, 8191)), 2, 4);
               @(negedge clock);
               vid_req = 1'b0;
               repeat (30) @(negedge clock);
            end
            stop = 1'b1;
         end
         begin
            while (!stop)
               cpu_access(1'($urandom_range(0, 1)), 14'($urandom_range(0, 8191)),
                          8'($urandom), 2, 4);
         end
      join
      repeat (10) @(negedge clock);
      check_val("vid_q_empty", vid_q.size(), 0);
      check_val("cpu_q_empty", cpu_q.size(), 0);
      check_val("stress_no_ovr", vid_overrun, 0);
      mism = 0;
      for (int a = 0; a < 16384; a++) if (ram[a] !== ref_ram[a]) mism++;
      check_val("ram_match", mism, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
